// File: rtl/power_seq_pkg.sv
// Shared state encodings for the power sequencer front end.
package power_seq_pkg;

  typedef enum logic [1:0] {
    PIdle,
    PHeld,
    PLong
  } press_state_e;

  typedef enum logic [1:0] {
    PwrOff,
    PwrOn,
    PwrArmOn,
    PwrArmOff
  } pwr_state_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-count debouncer with a registered rise strobe.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync_q2 != level) begin
        if (cnt_q == CNT_MAX) begin
          level <= sync_q2;
          rise  <= sync_q2;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/power_sequencer.sv
// Owns power_state: debounced keys, short/long press classification and gesture windows.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ            = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 300_000_000,
  parameter int unsigned GESTURE_W         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_power,
  input  logic                 key_left,
  input  logic                 key_right,
  input  logic [GESTURE_W-1:0] gesture_time,
  output logic                 power_state,
  output logic                 short_press,
  output logic                 long_press,
  output logic                 gesture_active,
  output logic [GESTURE_W-1:0] gesture_remaining
);

  localparam int unsigned HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic lvl_p, rise_p, lvl_l, rise_l, lvl_r, rise_r;
  logic unused_lvl;
  assign unused_lvl = lvl_l ^ lvl_r;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_power (
    .clk(clk), .reset(reset), .key_raw(key_power), .level(lvl_p), .rise(rise_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .reset(reset), .key_raw(key_left), .level(lvl_l), .rise(rise_l)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .reset(reset), .key_raw(key_right), .level(lvl_r), .rise(rise_r)
  );

  // Press classifier.
  press_state_e  press_q;
  logic [HW-1:0] hold_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_q     <= PIdle;
      hold_cnt_q  <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
      case (press_q)
        PIdle: begin
          if (rise_p) begin
            press_q    <= PHeld;
            hold_cnt_q <= '0;
          end
        end
        PHeld: begin
          if (!lvl_p) begin
            short_press <= (hold_cnt_q != HOLD_MAX);
            press_q     <= PIdle;
          end else if (hold_cnt_q == HOLD_MAX) begin
            long_press <= 1'b1;
            press_q    <= PLong;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        PLong: begin
          if (!lvl_p) press_q <= PIdle;
        end
        default: press_q <= PIdle;
      endcase
    end
  end

  // Power FSM and gesture window. Simultaneous left and right rises cancel out.
  logic                 gest_l, gest_r, presc_wrap, last_sec;
  logic [GESTURE_W-1:0] win_len;
  pwr_state_e           pwr_q;
  logic [PW-1:0]        presc_q;

  assign gest_l     = rise_l & ~rise_r;
  assign gest_r     = rise_r & ~rise_l;
  assign presc_wrap = (presc_q == PRESC_MAX);
  assign last_sec   = (gesture_remaining == GESTURE_W'(1));
  assign win_len    = (gesture_time == '0) ? GESTURE_W'(1) : gesture_time;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwr_q             <= PwrOff;
      presc_q           <= '0;
      power_state       <= 1'b0;
      gesture_active    <= 1'b0;
      gesture_remaining <= '0;
    end else begin
      case (pwr_q)
        PwrOff: begin
          if (short_press) begin
            pwr_q       <= PwrOn;
            power_state <= 1'b1;
          end else if (gest_l) begin
            pwr_q             <= PwrArmOn;
            gesture_active    <= 1'b1;
            gesture_remaining <= win_len;
            presc_q           <= '0;
          end
        end
        PwrOn: begin
          if (long_press) begin
            pwr_q       <= PwrOff;
            power_state <= 1'b0;
          end else if (gest_r) begin
            pwr_q             <= PwrArmOff;
            gesture_active    <= 1'b1;
            gesture_remaining <= win_len;
            presc_q           <= '0;
          end
        end
        PwrArmOn, PwrArmOff: begin
          // Power-key pulses beat gesture completion; completion beats expiry.
          if (short_press || long_press || (pwr_q == PwrArmOn ? gest_r : gest_l) ||
              (presc_wrap && last_sec)) begin
            gesture_active    <= 1'b0;
            gesture_remaining <= '0;
            presc_q           <= '0;
            if (short_press) begin
              pwr_q       <= PwrOn;
              power_state <= 1'b1;
            end else if (long_press) begin
              pwr_q       <= PwrOff;
              power_state <= 1'b0;
            end else if (pwr_q == PwrArmOn && gest_r) begin
              pwr_q       <= PwrOn;
              power_state <= 1'b1;
            end else if (pwr_q == PwrArmOff && gest_l) begin
              pwr_q       <= PwrOff;
              power_state <= 1'b0;
            end else begin
              pwr_q <= (pwr_q == PwrArmOn) ? PwrOff : PwrOn;
            end
          end else if (presc_wrap) begin
            presc_q           <= '0;
            gesture_remaining <= gesture_remaining - 1'b1;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: pwr_q <= PwrOff;
      endcase
    end
  end

endmodule
